// File: rtl/alu_ctrl_if.sv
// Command channel of alu_ctrl: one instruction per valid/ready handshake.
// The sequencer is the slave; whoever issues instructions is the master.
interface alu_ctrl_if #(
    parameter int W  = 4,
    parameter int AW = 2
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs;
    logic [AW-1:0] cmd_rt;
    logic [W-1:0]  cmd_imm;
    logic          cmd_use_ci;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
        output cmd_imm, cmd_use_ci,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt,
        input  cmd_imm, cmd_use_ci,
        output cmd_ready
    );
endinterface

// File: rtl/alu_ctrl.sv
// Two-cycle command sequencer around an external combinational ALU:
// reads operands from a small register file, drives the ALU from flops, writes back.
module alu_ctrl #(
    parameter int W  = 4,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_ctrl_if.slave    cmd,
    output logic [2:0]   alu_op_o,
    output logic [W-1:0] alu_a_o,
    output logic [W-1:0] alu_b_o,
    output logic         alu_ci_o,
    input  logic [W-1:0] alu_y_i,
    input  logic         alu_co_i,
    output logic         res_valid_o,
    output logic [W-1:0] res_data_o,
    output logic         res_co_o,
    output logic         err_o
);
    localparam int NREG = 1 << AW;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [W-1:0]  imm_q, imm_d;
    logic [2:0]    alu_op_q, alu_op_d;
    logic [W-1:0]  alu_a_q, alu_a_d;
    logic [W-1:0]  alu_b_q, alu_b_d;
    logic          alu_ci_q, alu_ci_d;
    logic          cflag_q, cflag_d;
    logic          res_valid_q, res_valid_d;
    logic [W-1:0]  res_data_q, res_data_d;
    logic          res_co_q, res_co_d;
    logic          err_q, err_d;
    logic [W-1:0]  rf_q [NREG];
    logic          rf_we;
    logic [W-1:0]  wdata;
    logic          accept;
    logic          arith;

    assign cmd.cmd_ready = (state_q == IDLE);
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign arith         = (cmd.cmd_op == OP_ADD) | (cmd.cmd_op == OP_SUB);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_ci_d    = alu_ci_q;
        cflag_d     = cflag_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_co_d    = res_co_q;
        err_d       = err_q;
        rf_we       = 1'b0;
        wdata       = '0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = cmd.cmd_op;
                    rd_d     = cmd.cmd_rd;
                    imm_d    = cmd.cmd_imm;
                    alu_op_d = cmd.cmd_op;
                    alu_a_d  = rf_q[cmd.cmd_rs];
                    alu_b_d  = rf_q[cmd.cmd_rt];
                    alu_ci_d = arith & cmd.cmd_use_ci & cflag_q;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                state_d     = IDLE;
                res_valid_d = 1'b1;
                unique case (op_q)
                    OP_ADD, OP_SUB: begin
                        rf_we   = 1'b1;
                        wdata   = alu_y_i;
                        cflag_d = alu_co_i;
                    end
                    OP_AND, OP_OR, OP_XOR: begin
                        rf_we = 1'b1;
                        wdata = alu_y_i;
                    end
                    OP_LOAD: begin
                        rf_we = 1'b1;
                        wdata = imm_q;
                    end
                    default: err_d = 1'b1;
                endcase
                res_data_d = wdata;
                res_co_d   = cflag_d;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ci_q    <= 1'b0;
            cflag_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_co_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_ci_q    <= alu_ci_d;
            cflag_q     <= cflag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_co_q    <= res_co_d;
            err_q       <= err_d;
        end
    end

    // Register file is cleared by reset so an aborted command leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rd_q] <= wdata;
        end
    end

    assign alu_op_o    = alu_op_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_ci_o    = alu_ci_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_co_o    = res_co_q;
    assign err_o       = err_q;
endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Command sequencer that sits directly upstream of the `alu_v2` combinational ALU and downstream of it for writeback. It accepts one instruction at a time over a valid/ready handshake and reads operands from a small internal register file. It drives registered `op`/`a`/`b`/`ci` into the ALU, then captures the ALU result and carry-out into the destination register and a carry flag, with a one-cycle result strobe. Multiword arithmetic is supported by optionally chaining the stored carry flag into the ALU carry-in.

## Interface
- `W`, 4: datapath width; must match the ALU instance.
- `AW`, 2: register-address width; the register file has 2^AW entries of W bits.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  3  000 LOAD, 001 ADD, 010 SUB, 100 AND, 101 OR, 110 XOR; 011 and 111 are illegal.
- `cmd_rd`, `cmd_rs`, `cmd_rt`  in  AW each  destination register, operand-a register, operand-b register.
- `cmd_imm`  in  W  immediate, used by LOAD only.
- `cmd_use_ci`  in  1  for ADD/SUB, drive the stored carry flag into `alu_ci`.
- `alu_op`  out  3  to ALU `op`.
- `alu_a`, `alu_b`  out  W  to ALU `a`, `b`.
- `alu_ci`  out  1  to ALU `ci`.
- `alu_y`  in  W  ALU result; combinational from `alu_*`.
- `alu_co`  in  1  ALU carry-out.
- `res_valid`  out  1  one-cycle strobe: a command has completed.
- `res_data`  out  W  value written (or that would have been written) to `rd`.
- `res_co`  out  1  carry flag after the command.
- `err`  out  1  sticky flag: an illegal op was received; cleared only by reset.

## Operation
- The FSM has two states, IDLE and EXEC. Reset state is IDLE.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`, the block latches `op`, `rd`, `imm` and `use_ci`.
  - It also loads `alu_op` = `cmd_op`, `alu_a` = RF[`cmd_rs`] and `alu_b` = RF[`cmd_rt`].
  - `alu_ci` = `cmd_use_ci & cflag` for ADD/SUB, else 0.
  - The FSM then moves to EXEC.
- **EXEC**
  - `cmd_ready` = 0; `alu_*` are held stable for the whole cycle.
  - At the end of the cycle, the FSM returns to IDLE and performs the writeback below.
- **Writeback by op**
  - ADD/SUB: RF[rd] <= `alu_y`, cflag <= `alu_co`.
  - AND/OR/XOR: RF[rd] <= `alu_y`; cflag is unchanged.
  - LOAD: RF[rd] <= `imm`; cflag is unchanged; the ALU output is ignored.
  - Illegal op: no register write, cflag unchanged, `err` <= 1; `res_valid` still pulses, with `res_data` = 0.
- **Result outputs:** `res_data` and `res_co` are registered at the EXEC→IDLE edge and hold until the next completion.
- **Hazards:** there are none. The next command is accepted at the earliest in the IDLE cycle that follows writeback, so it reads the updated register file. This includes the case `rs` = `rt` = `rd` of the previous command.
- **Arithmetic:** all values are unsigned modulo 2^W. The carry/borrow meaning of `alu_co` is the ALU's; the block stores it verbatim.
- **Reset mid-EXEC:** the command is aborted. No writeback occurs, `res_valid` stays 0, and the state is IDLE.

## Timing
- **Reset values:**
  - `cmd_ready` = 1.
  - `alu_op` = 0, `alu_a` = 0, `alu_b` = 0, `alu_ci` = 0.
  - `res_valid` = 0, `res_data` = 0, `res_co` = 0, `err` = 0.
  - All RF entries = 0 and cflag = 0.
- **Cycle map** (accept edge = cycle 0):
  - cycle 1 = EXEC with `alu_*` valid.
  - edge ending cycle 1 = writeback.
  - cycle 2 = `res_valid` high and `cmd_ready` high again.
- **Throughput:** one command per 2 cycles; back-to-back acceptance occurs on cycles 0, 2, 4, …
- **Handshake:**
  - `cmd_*` are sampled only on the accepting edge.
  - `cmd_valid` may be held high across completions.
  - Nothing is sampled while `cmd_ready` = 0.
- **Result-strobe overlap:** `res_valid` and a new acceptance may occur in the same cycle.
- **Critical path:** `alu_*` are driven from flops; the ALU combinational path ends at the RF/result flops.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-EXEC of an ADD → no `res_valid`, RF unchanged at 0, `cmd_ready` = 1 and all outputs 0 immediately (asynchronous).
- **LOAD then ADD wrap:** LOAD r0 = 4'hF, LOAD r1 = 4'h1, then ADD r2 = r0 + r1 with `use_ci` = 0 → `res_data` = 4'h0, `res_co` = 1, `res_valid` 2 cycles after acceptance.
- **Carry chain:** after the wrap above, ADD r3 = r1 + r1 with `use_ci` = 1 → `alu_ci` = 1 during EXEC, `res_data` = 4'h3, `res_co` = 0.
- **Logic ops keep flag:** with cflag = 1 and r0 = 4'hC, r1 = 4'hA:
  - AND → 4'h8.
  - OR → 4'hE.
  - XOR → 4'h6.
  - `res_co` stays 1 throughout.
- **Illegal and throughput:** send op 011 with `cmd_valid` held high, followed by 4 back-to-back commands → `err` = 1 and sticky, no RF write for the illegal op, acceptances exactly every 2 cycles.
- **Self-referencing:** SUB r0 = r0 − r0 immediately after LOAD r0 = 4'h5 → operand reads see 5, result 0, the register file contains r0 = 0.
